// File: rtl/sid_write_sequencer_if.sv
// Command stream and SID register-port bundle shared by the write sequencer
// and whatever feeds it; master drives commands, slave drives the SID port.
interface sid_write_sequencer_if #(
   parameter int DELAY_W = 20
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [4:0]         cmd_addr;
   logic [7:0]         cmd_data;
   logic [DELAY_W-1:0] cmd_delay;
   logic [4:0]         sid_a;
   logic [7:0]         sid_di;
   logic               sid_we;
   logic               sid_cs;

   modport master (
      output cmd_valid, cmd_addr, cmd_data, cmd_delay,
      input  cmd_ready, sid_a, sid_di, sid_we, sid_cs
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_data, cmd_delay,
      output cmd_ready, sid_a, sid_di, sid_we, sid_cs
   );
endinterface

// File: rtl/sid_write_sequencer.sv
// Queued SID register writer: FIFO of (addr, data, delay) commands replayed as
// single-cycle write strobes, each followed by a programmable idle gap.
module sid_write_sequencer #(
   parameter int DEPTH   = 16,
   parameter int DELAY_W = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pause,
   sid_write_sequencer_if.slave     bus,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 5 + 8 + DELAY_W;

   typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

   logic [EW-1:0]      mem [DEPTH];
   logic [AW-1:0]      wr_ptr_reg;
   logic [AW-1:0]      rd_ptr_reg;
   logic [AW:0]        count_reg;
   state_t             state_reg;
   logic [DELAY_W-1:0] cnt_reg;
   logic [4:0]         a_reg;
   logic [7:0]         di_reg;
   logic               we_reg;

   logic [EW-1:0]      head;
   logic               full;
   logic               push;
   logic               pop;

   assign head = mem[rd_ptr_reg];
   assign full = (count_reg == (AW+1)'(DEPTH));
   assign push = bus.cmd_valid && !full;
   // An issue decision is taken from IDLE, or from WRITE when the last write asked for no gap.
   assign pop  = (count_reg != '0) && !pause &&
                 ((state_reg == IDLE) || ((state_reg == WRITE) && (cnt_reg == '0)));

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= {bus.cmd_addr, bus.cmd_data, bus.cmd_delay};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // The counter already counts down during the strobe cycle, so a delay of d
   // puts the next issue decision exactly d cycles after the strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         a_reg     <= '0;
         di_reg    <= '0;
         we_reg    <= 1'b0;
      end else begin
         we_reg <= 1'b0;
         if (pop) begin
            a_reg     <= head[EW-1 -: 5];
            di_reg    <= head[DELAY_W +: 8];
            cnt_reg   <= head[DELAY_W-1:0];
            we_reg    <= 1'b1;
            state_reg <= WRITE;
         end else begin
            case (state_reg)
               IDLE: state_reg <= IDLE;
               WRITE: begin
                  if (cnt_reg <= DELAY_W'(1)) begin
                     cnt_reg   <= '0;
                     state_reg <= IDLE;
                  end else begin
                     cnt_reg   <= cnt_reg - 1'b1;
                     state_reg <= WAIT;
                  end
               end
               WAIT: begin
                  if (cnt_reg <= DELAY_W'(1)) begin
                     cnt_reg   <= '0;
                     state_reg <= IDLE;
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end
               default: begin
                  cnt_reg   <= '0;
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.cmd_ready = !full;
   assign bus.sid_a     = a_reg;
   assign bus.sid_di    = di_reg;
   assign bus.sid_we    = we_reg;
   assign bus.sid_cs    = we_reg;
   assign pending       = count_reg;
   assign busy          = (state_reg != IDLE) || (count_reg != '0);
endmodule
